x25519_ladder_ctrl: RTL and testbench

- Sequences the X25519 Montgomery-ladder step unit through a full 255-iteration scalar multiplication.
- Clamps the scalar, loads the initial projective state and performs constant-time conditional swaps between steps.
- Issues one step per scalar bit, captures the step results and returns projective (X2, Z2).
- Sits between the key-exchange top level (start/done handshake) and the single shared step unit. Field inversion is downstream, not in this block.

---
 rtl/x25519_ladder_ctrl_if.sv | 34 +++
 rtl/x25519_ladder_ctrl.sv | 159 +++++++++++++++
 tb/tb_x25519_ladder_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/x25519_ladder_ctrl_if.sv
// Bundle between the X25519 ladder controller, the key-exchange top level
// and the shared Montgomery-ladder step unit.
// master: environment side (top level + step unit); slave: the controller.
interface x25519_ladder_ctrl_if;
  logic         start;
  logic [255:0] scalar;
  logic [255:0] u_in;
  logic         busy;
  logic         done;
  logic [255:0] x2_out;
  logic [255:0] z2_out;
  logic         step_go;
  logic [255:0] step_x1;
  logic [255:0] step_x2;
  logic [255:0] step_z2;
  logic [255:0] step_x3;
  logic [255:0] step_z3;
  logic [255:0] step_x2n;
  logic [255:0] step_z2n;
  logic [255:0] step_x3n;
  logic [255:0] step_z3n;

  modport master (
    output start, scalar, u_in, step_x2n, step_z2n, step_x3n, step_z3n,
    input  busy, done, x2_out, z2_out, step_go,
           step_x1, step_x2, step_z2, step_x3, step_z3
  );

  modport slave (
    input  start, scalar, u_in, step_x2n, step_z2n, step_x3n, step_z3n,
    output busy, done, x2_out, z2_out, step_go,
           step_x1, step_x2, step_z2, step_x3, step_z3
  );
endinterface

// File: rtl/x25519_ladder_ctrl.sv
// X25519 Montgomery-ladder sequencer: clamps the scalar, loads the initial
// projective state, runs NBITS ladder steps on the shared step unit with
// constant-time masked conditional swaps, and returns projective (X2, Z2).
// Optional build macro X25519_CLAMP_EN: when defined, the scalar is clamped
// (bits 0..2 and 255 cleared, bit 254 set) at load; otherwise used raw.
// Schedule is fixed: every bit costs STEP_LAT+3 cycles regardless of data.
module x25519_ladder_ctrl #(
  parameter int STEP_LAT = 13,
  parameter int NBITS    = 255
) (
  input  logic clk,
  input  logic rst,
  x25519_ladder_ctrl_if.slave bus
);
  localparam int DATA_W = 256;
  localparam int CNT_W  = $clog2(STEP_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SWAP, S_GO, S_WAIT, S_CAPTURE, S_FINAL, S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] k;
  logic [DATA_W-1:0] x1;
  logic [DATA_W-1:0] x2;
  logic [DATA_W-1:0] z2;
  logic [DATA_W-1:0] x3;
  logic [DATA_W-1:0] z3;
  logic              swap;
  logic [7:0]        bit_idx;
  logic [CNT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] x2_res;
  logic [DATA_W-1:0] z2_res;
  logic              cswap_bit;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] dx;
  logic [DATA_W-1:0] dz;

  function automatic logic [DATA_W-1:0] clamp_scalar(input logic [DATA_W-1:0] k_raw);
`ifdef X25519_CLAMP_EN
    return {2'b01, k_raw[253:3], 3'b000};
`else
    return k_raw;
`endif
  endfunction

  // The top bit of u is not part of the encoding and is discarded.
  function automatic logic [DATA_W-1:0] mask_u(input logic [DATA_W-1:0] u_raw);
    return u_raw & {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; the sequence after LOAD never depends on data
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.start) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = S_SWAP;
      S_SWAP:    state_nxt = S_GO;
      S_GO:      state_nxt = S_WAIT;
      S_WAIT:    if (wait_cnt == CNT_W'(1)) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = (bit_idx == 8'd0) ? S_FINAL : S_SWAP;
      S_FINAL:   state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Control outputs; step_go follows rst so the step unit resets with us
  always_comb begin
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.step_go = rst;
    case (state)
      S_LOAD, S_SWAP, S_WAIT, S_CAPTURE, S_FINAL: bus.busy = 1'b1;
      S_GO: begin
        bus.busy    = 1'b1;
        bus.step_go = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Swap mask: the secret bit only ever gates an XOR, never a mux select
  always_comb begin
    cswap_bit = (state == S_FINAL) ? swap : (swap ^ k[bit_idx]);
    mask      = {DATA_W{cswap_bit}};
    dx        = (x2 ^ x3) & mask;
    dz        = (z2 ^ z3) & mask;
  end

  // Ladder state, bit index, wait counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      k        <= '0;
      x1       <= '0;
      x2       <= '0;
      z2       <= '0;
      x3       <= '0;
      z3       <= '0;
      swap     <= 1'b0;
      bit_idx  <= '0;
      wait_cnt <= '0;
      x2_res   <= '0;
      z2_res   <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          k        <= clamp_scalar(bus.scalar);
          x1       <= mask_u(bus.u_in);
          x2       <= DATA_W'(1);
          z2       <= '0;
          x3       <= mask_u(bus.u_in);
          z3       <= DATA_W'(1);
          swap     <= 1'b0;
          bit_idx  <= 8'(NBITS - 1);
          x2_res   <= '0;
          z2_res   <= '0;
        end
        S_SWAP: begin
          x2   <= x2 ^ dx;
          x3   <= x3 ^ dx;
          z2   <= z2 ^ dz;
          z3   <= z3 ^ dz;
          swap <= k[bit_idx];
        end
        S_GO:   wait_cnt <= CNT_W'(STEP_LAT);
        S_WAIT: wait_cnt <= wait_cnt - CNT_W'(1);
        S_CAPTURE: begin
          x2 <= bus.step_x2n;
          z2 <= bus.step_z2n;
          x3 <= bus.step_x3n;
          z3 <= bus.step_z3n;
          if (bit_idx != 8'd0) bit_idx <= bit_idx - 8'd1;
        end
        S_FINAL: begin
          x2_res <= x2 ^ dx;
          z2_res <= z2 ^ dz;
        end
        default: ;
      endcase
    end
  end

  assign bus.x2_out  = x2_res;
  assign bus.z2_out  = z2_res;
  assign bus.step_x1 = x1;
  assign bus.step_x2 = x2;
  assign bus.step_z2 = z2;
  assign bus.step_x3 = x3;
  assign bus.step_z3 = z3;
endmodule

// File: tb/tb_x25519_ladder_ctrl.sv
// Bench for x25519_ladder_ctrl: models the step unit (echo or true RFC 7748
// ladder step, latency STEP_LAT, junk outputs until ready) and checks
// latency, handshake, swap behaviour and results against expected values.
module tb_x25519_ladder_ctrl;
  localparam int STEP_LAT = 13;
  localparam int NBITS    = 255;
  localparam int EXP_LAT  = 2 + NBITS * (STEP_LAT + 3);
  localparam logic [255:0] P =
    256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam logic [255:0] MASK255 = {1'b0, {255{1'b1}}};
  localparam logic [255:0] JUNK    = {8{32'hdeadbeef}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  x25519_ladder_ctrl_if ifc();
  x25519_ladder_ctrl #(.STEP_LAT(STEP_LAT), .NBITS(NBITS)) dut (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- field arithmetic mod 2^255-19 ----------------
  function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = ({1'b0, a} + {1'b0, b}) % {1'b0, P};
    return s[255:0];
  endfunction

  function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] aa, bb, s;
    aa = {1'b0, a} % {1'b0, P};
    bb = {1'b0, b} % {1'b0, P};
    s  = (aa + {1'b0, P} - bb) % {1'b0, P};
    return s[255:0];
  endfunction

  function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] m;
    m = ({256'd0, a} * {256'd0, b}) % {256'd0, P};
    return m[255:0];
  endfunction

  function automatic logic [255:0] finv(input logic [255:0] z);
    logic [255:0] r, e;
    r = 256'd1;
    e = P - 256'd2;
    for (int i = 254; i >= 0; i--) begin
      r = fmul(r, r);
      if (e[i]) r = fmul(r, z);
    end
    return r;
  endfunction

  // RFC 7748 ladder step, returns {x2n, z2n, x3n, z3n}
  function automatic logic [1023:0] ladder_step(input logic [255:0] x1, input logic [255:0] x2,
      input logic [255:0] z2, input logic [255:0] x3, input logic [255:0] z3);
    logic [255:0] a, aa, b, bb, e, c, d, da, cb, sp, sm;
    a  = fadd(x2, z2);  aa = fmul(a, a);
    b  = fsub(x2, z2);  bb = fmul(b, b);
    e  = fsub(aa, bb);
    c  = fadd(x3, z3);  d  = fsub(x3, z3);
    da = fmul(d, a);    cb = fmul(c, b);
    sp = fadd(da, cb);  sm = fsub(da, cb);
    return {fmul(aa, bb), fmul(e, fadd(aa, fmul(256'd121665, e))),
            fmul(sp, sp), fmul(x1, fmul(sm, sm))};
  endfunction

  function automatic logic [255:0] bswap(input logic [255:0] h);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = h[255-8*i -: 8];
    return r;
  endfunction

  function automatic logic [255:0] clamp(input logic [255:0] kk);
    logic [255:0] r;
    r = kk;
    r[2:0] = 3'b000;
    r[255] = 1'b0;
    r[254] = 1'b1;
    return r;
  endfunction

  function automatic logic [255:0] k_eff(input logic [255:0] kk);
`ifdef X25519_CLAMP_EN
    return clamp(kk);
`else
    return kk;
`endif
  endfunction

  // Reference ladder (RFC 7748 pseudocode), projective result
  task automatic ref_ladder(input logic [255:0] k_raw, input logic [255:0] uu,
      output logic [255:0] rx2, output logic [255:0] rz2);
    logic [255:0] kk, x1, x2, z2, x3, z3, t;
    logic [1023:0] r;
    bit sw, kt;
    kk = k_eff(k_raw);
    x1 = uu & MASK255; x2 = 256'd1; z2 = 256'd0; x3 = x1; z3 = 256'd1; sw = 1'b0;
    for (int i = NBITS - 1; i >= 0; i--) begin
      kt = kk[i];
      sw = sw ^ kt;
      if (sw) begin
        t = x2; x2 = x3; x3 = t;
        t = z2; z2 = z3; z3 = t;
      end
      sw = kt;
      r = ladder_step(x1, x2, z2, x3, z3);
      {x2, z2, x3, z3} = r;
    end
    if (sw) begin
      t = x2; x2 = x3; x3 = t;
      t = z2; z2 = z3; z3 = t;
    end
    rx2 = x2;
    rz2 = z2;
  endtask

  // ---------------- step unit model ----------------
  bit            echo_mode = 1'b1;
  int            sc = 0;
  logic [1023:0] res = '0;
  logic          ready;

  // Restart on step_go; results become valid once the latency has elapsed
  always @(posedge clk) begin
    if (ifc.step_go) sc <= STEP_LAT;
    else if (sc != 0) sc <= sc - 1;
    if (!ifc.step_go && sc == 1)
      res <= echo_mode ? {ifc.step_x2, ifc.step_z2, ifc.step_x3, ifc.step_z3}
                       : ladder_step(ifc.step_x1, ifc.step_x2, ifc.step_z2,
                                     ifc.step_x3, ifc.step_z3);
  end

  assign ready        = (sc == 0) && !ifc.step_go;
  assign ifc.step_x2n = ready ? res[1023:768] : JUNK;
  assign ifc.step_z2n = ready ? res[767:512]  : JUNK;
  assign ifc.step_x3n = ready ? res[511:256]  : JUNK;
  assign ifc.step_z3n = ready ? res[255:0]    : JUNK;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [255:0] kk, input logic [255:0] uu, input int pulse_at,
      output int lat, output int ngo, output bit busy_ok, output bit busy_at_done,
      output bit done_after, output logic [255:0] x1_seen);
    lat = 0; ngo = 0; busy_ok = 1'b1; busy_at_done = 1'b1; done_after = 1'b1; x1_seen = '0;
    @(posedge clk); #1;
    ifc.scalar = kk; ifc.u_in = uu; ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    while (lat < EXP_LAT + 200) begin
      if (ifc.done) break;
      if (!ifc.busy) busy_ok = 1'b0;
      if (ifc.step_go) begin
        if (ngo == 0) x1_seen = ifc.step_x1;
        ngo++;
      end
      ifc.start = (lat == pulse_at);
      @(posedge clk); #1;
      lat++;
    end
    busy_at_done = ifc.busy;
    ifc.start = 1'b0;
    @(posedge clk); #1;
    done_after = ifc.done;
  endtask

  typedef struct {
    bit           echo;
    logic [255:0] k;
    logic [255:0] u;
    bit           affine;
    logic [255:0] ex2;
    logic [255:0] ez2;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ngo, lat0, lat1, ndone;
    bit bok, bdone, dafter;
    logic [255:0] x1s, rx2, rz2, kb;

    vecs[0] = '{1'b1, {256{1'b1}}, 256'd9, 1'b0, 256'd1, 256'd0};
    vecs[1] = '{1'b1, 256'd0, {256{1'b1}}, 1'b0, 256'd1, 256'd0};
    vecs[2] = '{1'b1, {64{4'h5}}, 256'h1234, 1'b0, 256'd1, 256'd0};
    vecs[3] = '{1'b0, {8{32'h13579bdf}}, 256'd0, 1'b1, 256'd0, 256'd0};
    vecs[4] = '{1'b0,
      clamp(bswap(256'ha546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4)),
      bswap(256'he6db6867583030db3594c1a424b15f7c726624ec26b3353b10a903a6d0ab1c4c),
      1'b1,
      bswap(256'hc3da55379de9c6908e94ea4df28d084f32eccf03491c71f754b4075577a28552),
      256'd0};

    ifc.start = 1'b0; ifc.scalar = '0; ifc.u_in = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 256'(ifc.busy), 256'd0);
    chk("reset_done", 256'(ifc.done), 256'd0);
    chk("reset_x2_out", ifc.x2_out, 256'd0);
    chk("reset_z2_out", ifc.z2_out, 256'd0);
    chk("reset_step_go", 256'(ifc.step_go), 256'd1);

    // start together with rst: rst wins
    ifc.start = 1'b1;
    @(posedge clk); #1;
    chk("start_under_rst_busy", 256'(ifc.busy), 256'd0);
    ifc.start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_step_go", 256'(ifc.step_go), 256'd0);
    chk("idle_busy", 256'(ifc.busy), 256'd0);

    for (int i = 0; i < 5; i++) begin
      echo_mode = vecs[i].echo;
      run_op(vecs[i].k, vecs[i].u, -1, lat, ngo, bok, bdone, dafter, x1s);
      chk_int($sformatf("row%0d_latency", i), lat, EXP_LAT);
      chk_int($sformatf("row%0d_step_go_count", i), ngo, NBITS);
      chk_int($sformatf("row%0d_busy_continuous", i), int'(bok), 1);
      chk_int($sformatf("row%0d_busy_at_done", i), int'(bdone), 0);
      chk_int($sformatf("row%0d_done_one_cycle", i), int'(dafter), 0);
      chk($sformatf("row%0d_x1_masked", i), x1s, vecs[i].u & MASK255);
      if (vecs[i].affine) begin
        chk($sformatf("row%0d_affine_u", i), fmul(ifc.x2_out, finv(ifc.z2_out)), vecs[i].ex2);
      end else begin
        chk($sformatf("row%0d_x2_out", i), ifc.x2_out, vecs[i].ex2);
        chk($sformatf("row%0d_z2_out", i), ifc.z2_out, vecs[i].ez2);
      end
    end

    // Scalars differing only in bit 0: same latency, each matches the reference
    echo_mode = 1'b0;
    kb = {16{16'h6a3c}} & ~256'd1;
    run_op(kb, 256'd9, -1, lat0, ngo, bok, bdone, dafter, x1s);
    ref_ladder(kb, 256'd9, rx2, rz2);
    chk("bit0_clear_x2", ifc.x2_out, rx2);
    chk("bit0_clear_z2", ifc.z2_out, rz2);
    run_op(kb | 256'd1, 256'd9, -1, lat1, ngo, bok, bdone, dafter, x1s);
    ref_ladder(kb | 256'd1, 256'd9, rx2, rz2);
    chk("bit0_set_x2", ifc.x2_out, rx2);
    chk("bit0_set_z2", ifc.z2_out, rz2);
    chk_int("bit0_latency_equal", lat1, lat0);
    chk_int("bit0_latency", lat0, EXP_LAT);

    // start pulse while busy is ignored and not queued
    echo_mode = 1'b1;
    run_op({32{8'h96}}, 256'd77, 100, lat, ngo, bok, bdone, dafter, x1s);
    chk_int("pulse_latency", lat, EXP_LAT);
    chk_int("pulse_busy_continuous", int'(bok), 1);
    chk_int("pulse_done_one_cycle", int'(dafter), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("pulse_not_queued_busy", 256'(ifc.busy), 256'd0);

    // Reset in the middle of an operation
    echo_mode = 1'b0;
    ndone = 0;
    @(posedge clk); #1;
    ifc.scalar = {8{32'h0f1e2d3c}}; ifc.u_in = 256'd9; ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (ifc.done) ndone++;
    end
    chk("abort_busy_before", 256'(ifc.busy), 256'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 256'(ifc.busy), 256'd0);
    chk("abort_x2_out", ifc.x2_out, 256'd0);
    chk("abort_z2_out", ifc.z2_out, 256'd0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ifc.done) ndone++;
    end
    chk_int("abort_no_done", ndone, 0);
    run_op(256'h1d, 256'd9, -1, lat, ngo, bok, bdone, dafter, x1s);
    ref_ladder(256'h1d, 256'd9, rx2, rz2);
    chk_int("after_abort_latency", lat, EXP_LAT);
    chk("after_abort_x2", ifc.x2_out, rx2);
    chk("after_abort_z2", ifc.z2_out, rz2);

    // start held high through DONE restarts on the first IDLE cycle
    echo_mode = 1'b1;
    @(posedge clk); #1;
    ifc.scalar = 256'd5; ifc.u_in = 256'd9; ifc.start = 1'b1;
    lat = 0;
    while (!ifc.done && lat < EXP_LAT + 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk_int("held_latency", lat, EXP_LAT + 1);
    @(posedge clk); #1;
    chk("held_idle_gap_busy", 256'(ifc.busy), 256'd0);
    @(posedge clk); #1;
    chk("held_restart_busy", 256'(ifc.busy), 256'd1);
    ifc.start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("held_abort_busy", 256'(ifc.busy), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
